// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake, thresholds and status of
// the parametrised FIFO; master drives requests, slave is the FIFO.
interface sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              write_enable;
   logic              read_enable;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W:0]   afull_thres;
   logic [ADDR_W:0]   aempty_thres;
   logic              clear_err;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              underflow;

   modport master (
      output write_enable, read_enable, data_in,
      output afull_thres, aempty_thres, clear_err,
      input  data_out, data_valid, empty, full,
      input  almost_full, almost_empty, level,
      input  overflow, underflow
   );

   modport slave (
      input  write_enable, read_enable, data_in,
      input  afull_thres, aempty_thres, clear_err,
      output data_out, data_valid, empty, full,
      output almost_full, almost_empty, level,
      output overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with level, thresholds, sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   sync_fifo_param_if.slave bus
);
   localparam logic [ADDR_W:0]   DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              is_empty, is_full;
   logic              wr_acc, rd_acc;

   assign is_empty = (level_q == '0);
   assign is_full  = (level_q == DEPTH_L);
   assign wr_acc   = bus.write_enable & ~is_full;
   assign rd_acc   = bus.read_enable & ~is_empty;

   // Next pointers, fill level and sticky error flags.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) rptr_d = rptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      ovf_d = (bus.write_enable & is_full)
            | (ovf_q & ~bus.clear_err);
      udf_d = (bus.read_enable & is_empty)
            | (udf_q & ~bus.clear_err);
   end

   // Control state; reset drops all contents at once.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage array, deliberately left unreset.
   always_ff @(posedge clock) begin
      if (reset_n && wr_acc) mem_q[wptr_q] <= bus.data_in;
   end

`ifdef FIFO_FWFT_EN
   assign bus.data_out   = mem_q[rptr_q];
   assign bus.data_valid = ~is_empty;
`else
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dval_q, dval_d;

   // Head word is captured only on an accepted read, else held.
   always_comb begin
      dout_d = dout_q;
      dval_d = rd_acc;
      if (rd_acc) dout_d = mem_q[rptr_q];
   end

   // Registered read port.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         dout_q <= '0;
         dval_q <= 1'b0;
      end else begin
         dout_q <= dout_d;
         dval_q <= dval_d;
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = dval_q;
`endif

   assign bus.empty        = is_empty;
   assign bus.full         = is_full;
   assign bus.level        = level_q;
   assign bus.almost_full  = (level_q >= bus.afull_thres);
   assign bus.almost_empty = (level_q <= bus.aempty_thres);
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed and random stimulus for sync_fifo_param
// against a queue-based model; honours FIFO_FWFT_EN.
module tb_sync_fifo_param;
   localparam int DW = 8;
   localparam int AW = 5;
   localparam int DEPTH = 32;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   bit   check_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endfunction

   // Reference model: contents as a queue, flags from its size.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   bit            m_dval = 1'b0;
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;

   always @(posedge clock) begin
      bit f, e, wa, ra;
      if (!reset_n) begin
         q.delete();
         m_dout = '0;
         m_dval = 1'b0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         f  = (q.size() == DEPTH);
         e  = (q.size() == 0);
         wa = bus.write_enable && !f;
         ra = bus.read_enable && !e;
         m_ovf = (bus.write_enable && f) || (m_ovf && !bus.clear_err);
         m_udf = (bus.read_enable && e) || (m_udf && !bus.clear_err);
         m_dval = ra;
         if (ra) m_dout = q.pop_front();
         if (wa) q.push_back(bus.data_in);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clock) begin
      if (check_en) begin
         chk("level", bus.level, q.size());
         chk("empty", bus.empty, q.size() == 0);
         chk("full", bus.full, q.size() == DEPTH);
         chk("almost_full", bus.almost_full,
             q.size() >= int'(bus.afull_thres));
         chk("almost_empty", bus.almost_empty,
             q.size() <= int'(bus.aempty_thres));
         chk("overflow", bus.overflow, m_ovf);
         chk("underflow", bus.underflow, m_udf);
`ifdef FIFO_FWFT_EN
         chk("data_valid", bus.data_valid, q.size() != 0);
         if (q.size() != 0) chk("data_out", bus.data_out, q[0]);
`else
         chk("data_valid", bus.data_valid, m_dval);
         chk("data_out", bus.data_out, m_dout);
`endif
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic idle();
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b0;
      bus.clear_err    = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic fill(input logic [DW-1:0] base);
      bus.write_enable = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.data_in = base + DW'(i);
         tick();
      end
      bus.write_enable = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.clear_err = 1'b1;
      tick();
      bus.clear_err = 1'b0;
   endtask

   logic [DW-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
   int wp, rp;

   initial begin
      idle();
      bus.data_in      = '0;
      bus.afull_thres  = 6'd30;
      bus.aempty_thres = 6'd2;
      do_reset();
      check_en = 1'b1;
      chk("rst_level", bus.level, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_dout", bus.data_out, 0);

      // three writes then three reads
      bus.write_enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.data_in = vals[i];
         tick();
      end
      bus.write_enable = 1'b0;
      chk("t1_level", bus.level, 3);
      chk("t1_empty", bus.empty, 0);
      for (int i = 0; i < 3; i++) begin
`ifdef FIFO_FWFT_EN
         chk("t1_head", bus.data_out, vals[i]);
`endif
         bus.read_enable = 1'b1;
         tick();
`ifndef FIFO_FWFT_EN
         chk("t1_rdata", bus.data_out, vals[i]);
         chk("t1_rvalid", bus.data_valid, 1);
`endif
      end
      bus.read_enable = 1'b0;
      tick();
      chk("t1_drained", bus.level, 0);
      chk("t1_valid_off", bus.data_valid, 0);

      // fill to full with almost_full at 30, then one extra write
      bus.write_enable = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.data_in = 8'h40 + DW'(i);
         tick();
         chk("t2_afull", bus.almost_full, (i + 1) >= 30);
      end
      chk("t2_full", bus.full, 1);
      bus.data_in = 8'hEE;
      tick();
      bus.write_enable = 1'b0;
      chk("t2_ovf_level", bus.level, 32);
      chk("t2_ovf", bus.overflow, 1);
`ifdef FIFO_FWFT_EN
      chk("t2_head", bus.data_out, 8'h40);
`endif
      bus.read_enable = 1'b1;
      tick();
`ifndef FIFO_FWFT_EN
      chk("t2_first", bus.data_out, 8'h40);
`endif
      for (int i = 1; i < DEPTH; i++) tick();
      bus.read_enable = 1'b0;
      tick();
      chk("t2_drained", bus.level, 0);
      pulse_clear();
      chk("t2_clear", bus.overflow, 0);

      // read from reset-empty
      do_reset();
      bus.read_enable = 1'b1;
      tick();
      bus.read_enable = 1'b0;
      chk("t3_udf", bus.underflow, 1);
      chk("t3_dval", bus.data_valid, 0);
`ifndef FIFO_FWFT_EN
      chk("t3_dout", bus.data_out, 0);
`endif
      pulse_clear();
      chk("t3_clear", bus.underflow, 0);

      // simultaneous read/write at full and at empty
      fill(8'h80);
      bus.write_enable = 1'b1;
      bus.read_enable  = 1'b1;
      bus.data_in      = 8'hFF;
      tick();
      idle();
      chk("t4_full_rw_lvl", bus.level, 31);
      chk("t4_full_rw_ovf", bus.overflow, 1);
`ifdef FIFO_FWFT_EN
      chk("t4_next_head", bus.data_out, 8'h81);
`else
      chk("t4_popped", bus.data_out, 8'h80);
`endif
      bus.read_enable = 1'b1;
      for (int i = 0; i < 31; i++) tick();
      bus.read_enable = 1'b0;
      chk("t4_drained", bus.level, 0);
      bus.write_enable = 1'b1;
      bus.read_enable  = 1'b1;
      bus.data_in      = 8'h5A;
      tick();
      idle();
      chk("t4_empty_rw_lvl", bus.level, 1);
      chk("t4_empty_rw_udf", bus.underflow, 1);
      bus.read_enable = 1'b1;
      tick();
      bus.read_enable = 1'b0;
      pulse_clear();

      // 100-word streaming with pointer wrap
      bus.write_enable = 1'b1;
      bus.data_in = 8'd0;
      tick();
      bus.read_enable = 1'b1;
      for (int i = 1; i < 100; i++) begin
         bus.data_in = DW'(i * 7);
         tick();
         chk("t5_level", bus.level, 1);
      end
      bus.write_enable = 1'b0;
      tick();
      bus.read_enable = 1'b0;
      chk("t5_end_level", bus.level, 0);
      chk("t5_ovf", bus.overflow, 0);
      chk("t5_udf", bus.underflow, 0);

      // reset while holding seven words and an error
      bus.read_enable = 1'b1;
      tick();
      bus.read_enable = 1'b0;
      bus.write_enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus.data_in = 8'hC0 + DW'(i);
         tick();
`ifdef FIFO_FWFT_EN
         if (i == 0) chk("t6_fwft_head", bus.data_out, 8'hC0);
`endif
      end
      bus.write_enable = 1'b0;
      chk("t6_level7", bus.level, 7);
      chk("t6_udf_set", bus.underflow, 1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t6_level0", bus.level, 0);
      chk("t6_empty", bus.empty, 1);
      chk("t6_dval", bus.data_valid, 0);
      chk("t6_udf_clr", bus.underflow, 0);
      chk("t6_ovf_clr", bus.overflow, 0);

      // random traffic, thresholds, clears and resets
      wp = 50;
      rp = 50;
      for (int n = 0; n < 4000; n++) begin
         if (n % 200 == 0) begin
            wp = $urandom_range(20, 80);
            rp = $urandom_range(20, 80);
         end
         bus.write_enable = ($urandom_range(0, 99) < wp);
         bus.read_enable  = ($urandom_range(0, 99) < rp);
         bus.data_in      = DW'($urandom);
         bus.clear_err    = ($urandom_range(0, 39) == 0);
         reset_n          = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 19) == 0)
            bus.afull_thres = 6'($urandom_range(0, 40));
         if ($urandom_range(0, 19) == 0)
            bus.aempty_thres = 6'($urandom_range(0, 40));
         tick();
      end
      idle();
      reset_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: the next generation of the team's 8-bit/32-entry buffer. It adds configurable data width and depth, a true full flag alongside programmable almost-full/almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags. It sits between byte/word producers and consumers in a single clock domain, for example a UART RX path feeding a packet parser. Read data is registered by default; first-word-fall-through is a compile-time option.

## Interface
- DATA_W, 8, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- clock  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- write_enable  in  1  write request
- read_enable  in  1  read request
- data_in  in  DATA_W  write data
- afull_thres  in  ADDR_W+1  almost-full threshold, in entries
- aempty_thres  in  ADDR_W+1  almost-empty threshold, in entries
- clear_err  in  1  clears overflow/underflow
- data_out  out  DATA_W  read data
- data_valid  out  1  data_out holds newly read data
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_full  out  1  level >= afull_thres
- almost_empty  out  1  level <= aempty_thres
- level  out  ADDR_W+1  current entry count, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Write accept: wr_acc = write_enable & ~full. Read accept: rd_acc = read_enable & ~empty. Acceptance is evaluated on pre-edge flags.
- Full with simultaneous read and write: the read is accepted, the write is rejected, overflow sets, and level decrements.
- Empty with simultaneous read and write: the write is accepted, the read is rejected, underflow sets, and level increments (standard mode).
- Both accepted: level is unchanged and both pointers advance.
- Pointers are ADDR_W bits wide and wrap modulo DEPTH with no special handling. level is a separate ADDR_W+1-bit counter.
- Memory is DEPTH x DATA_W, written on wr_acc at write_ptr. It is not reset.
- Error flags: overflow sets on write_enable & full; underflow sets on read_enable & empty. Both are cleared by clear_err=1 or reset.
- Error flag priority: a set in the same cycle as clear_err wins, so the flag stays 1.
- Thresholds are sampled combinationally every cycle and may change at any time. A threshold above DEPTH means almost_full never asserts.
- Reset values: level 0, pointers 0, data_out 0, data_valid 0, overflow 0, underflow 0, empty 1, full 0. almost_full and almost_empty follow their comparisons.
- Reset mid-operation: all contents are discarded immediately, and accepts in the reset cycle are ignored.

## Timing
- All flags and level are combinational from registered state, so they update the cycle after the accepting edge.
- Write-to-read: data written at edge N is readable (empty=0) from the cycle after edge N.
- Standard-mode read: data_out is registered from memory[read_ptr] on rd_acc at edge N and is valid after edge N with data_valid=1 for one cycle.
- Standard-mode hold: data_out holds its last value when no read is accepted.
- Standard-mode throughput: back-to-back reads sustain one word per cycle.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - data_out = memory[read_ptr] combinationally, and data_valid = ~empty.
  - The head word is visible without a read; rd_acc pops it at the edge, so read latency is 0.
  - data_out is don't-care while empty.
- FIFO_FWFT_EN undefined: the registered one-cycle-latency read described under Timing.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 on three consecutive cycles -> level=3, empty=0; three reads return 0x11, 0x22, 0x33 in order with data_valid 1 cycle after each (standard mode) and level=0.
- Fill to DEPTH=32 with afull_thres=30 -> almost_full rises when level reaches 30 and full when level reaches 32; a 33rd write -> level stays 32, overflow=1, no data corrupted.
- Read from reset-empty -> underflow=1, data_out stays 0, data_valid=0; pulse clear_err -> underflow=0.
- Full FIFO with write_enable and read_enable both high for one cycle -> level 32->31, overflow=1, head word popped; empty FIFO with both high -> level 0->1, underflow=1.
- Write and read 100 words continuously with wrap -> pointers wrap past 31, every output matches input, level stays ≤1, and no error flags set.
- Assert reset_n=0 at level=7 -> next cycle level=0, empty=1, data_valid=0, errors cleared. Repeat with FIFO_FWFT_EN defined, checking data_out equals the head word immediately after the first write.
